pipe_chain: RTL and testbench

- Parametrised N-stage valid/allow_in pipeline skeleton with a per-stage payload register. It is the next generation of the CPU's hand-wired IF/ID/EX/MEM/WB valid chain.
- Each stage has an external ready_go, so stage logic (decode, ALU, memory wait) can hold its entry.
- A single flush port kills all younger stages, e.g. on a branch redirect.
- The top level instantiates it once; stage logic reads each stage's payload and writes back through its ready_go.

---
 rtl/pipe_chain.sv | 154 +++++++++++++++
 tb/tb_pipe_chain.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain.sv
// N-stage valid/allow_in pipeline chain with per-stage payload and flush.
// Optional PIPE_CHAIN_PERF_EN adds stall/bubble/kill counters.
module pipe_chain #(
    parameter int NUM_STAGES = 5,
    parameter int DATA_WIDTH = 64,
    parameter int FS_W       = $clog2(NUM_STAGES + 1)
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             in_valid,
    output logic                             in_allow_in,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic [NUM_STAGES-1:0]            stage_ready_go,
    input  logic                             flush_req,
    input  logic [FS_W-1:0]                  flush_stage,
    output logic [NUM_STAGES-1:0]            stage_valid,
    output logic [NUM_STAGES*DATA_WIDTH-1:0] stage_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data
`ifdef PIPE_CHAIN_PERF_EN
    ,
    output logic [31:0]                      perf_stall_cnt,
    output logic [31:0]                      perf_bubble_cnt,
    output logic [31:0]                      perf_kill_cnt
`endif
);

    localparam int N = NUM_STAGES;

    logic [N-1:0]          v_q;
    logic [N-1:0]          v_d;
    logic [DATA_WIDTH-1:0] d_q [N];
    logic [DATA_WIDTH-1:0] d_d [N];

    logic [N-1:0]          allow_in;
    logic [N-1:0]          kill;
    logic [N-1:0]          to_next;
    logic [N-1:0]          src;
    logic [DATA_WIDTH-1:0] src_data [N];
    logic [FS_W-1:0]       k_eff;

    always_comb begin
        if (flush_stage > FS_W'(N)) begin
            k_eff = FS_W'(N);
        end else begin
            k_eff = flush_stage;
        end
    end

    always_comb begin
        kill = '0;
        for (int i = 0; i < N; i++) begin
            kill[i] = flush_req & (FS_W'(i) < k_eff);
        end
    end

    // Walk from the oldest stage so backpressure settles in one pass.
    always_comb begin
        logic a;
        a        = out_ready;
        allow_in = '0;
        for (int i = N - 1; i >= 0; i--) begin
            a           = ~v_q[i] | (stage_ready_go[i] & a);
            allow_in[i] = a;
        end
    end

    assign to_next = v_q & stage_ready_go & ~kill;
    assign src     = {to_next[N-2:0], in_valid & ~flush_req};

    always_comb begin
        src_data[0] = in_data;
        for (int i = 1; i < N; i++) begin
            src_data[i] = d_q[i-1];
        end
    end

    always_comb begin
        v_d = v_q;
        for (int i = 0; i < N; i++) begin
            d_d[i] = d_q[i];
            if (allow_in[i]) begin
                v_d[i] = src[i];
                if (src[i]) begin
                    d_d[i] = src_data[i];
                end
            end else if (kill[i]) begin
                v_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_q <= '0;
            for (int i = 0; i < N; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int i = 0; i < N; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    assign in_allow_in = allow_in[0];
    assign out_valid   = to_next[N-1];
    assign out_data    = d_q[N-1];
    assign stage_valid = v_q;

    for (genvar g = 0; g < N; g++) begin : g_data
        assign stage_data[g*DATA_WIDTH +: DATA_WIDTH] = d_q[g];
    end

`ifdef PIPE_CHAIN_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] stall_d;
    logic [31:0] bubble_q;
    logic [31:0] bubble_d;
    logic [31:0] kcnt_q;
    logic [31:0] kcnt_d;
    logic [31:0] kills;

    always_comb begin
        kills = '0;
        for (int i = 0; i < N; i++) begin
            kills = kills + 32'(v_q[i] & kill[i]);
        end
        stall_d  = stall_q
                 + 32'(in_valid & ~in_allow_in & ~flush_req);
        bubble_d = bubble_q + 32'(out_ready & ~out_valid);
        kcnt_d   = kcnt_q + kills;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_q  <= '0;
            bubble_q <= '0;
            kcnt_q   <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
            kcnt_q   <= kcnt_d;
        end
    end

    assign perf_stall_cnt  = stall_q;
    assign perf_bubble_cnt = bubble_q;
    assign perf_kill_cnt   = kcnt_q;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Randomized bench for pipe_chain against a slot-level reference model.
// Directed phases cover streaming, stalls, backpressure, flush and reset.
module tb_pipe_chain;

    localparam int N   = 5;
    localparam int DW  = 64;
    localparam int FSW = $clog2(N + 1);
    localparam int SW  = N * DW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_allow_in;
    logic [DW-1:0] in_data;
    logic [N-1:0]  stage_ready_go;
    logic          flush_req;
    logic [FSW-1:0] flush_stage;
    logic [N-1:0]  stage_valid;
    logic [SW-1:0] stage_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
`ifdef PIPE_CHAIN_PERF_EN
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_bubble_cnt;
    logic [31:0]   perf_kill_cnt;
`endif

    pipe_chain #(
        .NUM_STAGES(N),
        .DATA_WIDTH(DW)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_allow_in    (in_allow_in),
        .in_data        (in_data),
        .stage_ready_go (stage_ready_go),
        .flush_req      (flush_req),
        .flush_stage    (flush_stage),
        .stage_valid    (stage_valid),
        .stage_data     (stage_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data)
`ifdef PIPE_CHAIN_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_bubble_cnt(perf_bubble_cnt),
        .perf_kill_cnt  (perf_kill_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag,
                       input logic [SW-1:0] got,
                       input logic [SW-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one slot per stage, oldest at N-1.
    bit            mv [N];
    logic [DW-1:0] md [N];
    int unsigned   m_stall;
    int unsigned   m_bubble;
    int unsigned   m_kill;
    logic [63:0]   seq;

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
        m_stall  = 0;
        m_bubble = 0;
        m_kill   = 0;
    endtask

    task automatic step(input bit iv, input logic [DW-1:0] id,
                        input logic [N-1:0] rg, input bit fr,
                        input logic [FSW-1:0] fs, input bit ordy);
        int            k;
        bit            kl [N];
        bit            room [N];
        bit            a;
        bit            ov;
        bit            inc;
        bit            nv [N];
        logic [DW-1:0] nd [N];
        logic [N-1:0]  e_sv;
        logic [SW-1:0] e_sd;
        int unsigned   nk;
        in_valid       = iv;
        in_data        = id;
        stage_ready_go = rg;
        flush_req      = fr;
        flush_stage    = fs;
        out_ready      = ordy;
        k = (int'(fs) > N) ? N : int'(fs);
        for (int i = 0; i < N; i++) begin
            kl[i] = fr && (i < k);
        end
        // A slot has room if empty, or its occupant leaves and the next has room.
        a = ordy;
        for (int i = N - 1; i >= 0; i--) begin
            a       = !mv[i] || (rg[i] && a);
            room[i] = a;
        end
        ov = mv[N-1] && rg[N-1] && !kl[N-1];
        e_sv = '0;
        e_sd = '0;
        for (int i = 0; i < N; i++) begin
            e_sv[i] = mv[i];
            e_sd[i*DW +: DW] = md[i];
        end
        #4;
        chk("in_allow_in", SW'(in_allow_in), SW'(room[0]));
        chk("out_valid", SW'(out_valid), SW'(ov));
        chk("out_data", SW'(out_data), SW'(md[N-1]));
        chk("stage_valid", SW'(stage_valid), SW'(e_sv));
        chk("stage_data", stage_data, e_sd);
`ifdef PIPE_CHAIN_PERF_EN
        chk("perf_stall", SW'(perf_stall_cnt), SW'(m_stall));
        chk("perf_bubble", SW'(perf_bubble_cnt), SW'(m_bubble));
        chk("perf_kill", SW'(perf_kill_cnt), SW'(m_kill));
`endif
        nk = 0;
        for (int i = 0; i < N; i++) begin
            if (mv[i] && kl[i]) nk++;
            if (i == 0) begin
                inc = iv && !fr;
            end else begin
                inc = mv[i-1] && rg[i-1] && !kl[i-1];
            end
            nv[i] = mv[i];
            nd[i] = md[i];
            if (room[i]) begin
                nv[i] = inc;
                if (inc) nd[i] = (i == 0) ? id : md[(i > 0) ? i - 1 : 0];
            end else if (kl[i]) begin
                nv[i] = 1'b0;
            end
        end
        if (iv && !room[0] && !fr) m_stall++;
        if (ordy && !ov) m_bubble++;
        m_kill += nk;
        for (int i = 0; i < N; i++) begin
            mv[i] = nv[i];
            md[i] = nd[i];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int c = 0; c < n; c++) step(0, '0, '1, 0, '0, ordy);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sv"}, SW'(stage_valid), '0);
        chk({tag, "_ov"}, SW'(out_valid), '0);
        chk({tag, "_sd"}, stage_data, '0);
        chk({tag, "_od"}, SW'(out_data), '0);
        chk({tag, "_ai"}, SW'(in_allow_in), SW'(1'b1));
    endtask

    initial begin
        int            p_in;
        int            p_rg;
        int            p_or;
        int            p_fl;
        logic [N-1:0]  rg;
        logic [DW-1:0] dv;
        resetn         = 1'b0;
        in_valid       = 1'b0;
        in_data        = '0;
        stage_ready_go = '0;
        flush_req      = 1'b0;
        flush_stage    = '0;
        out_ready      = 1'b0;
        seq            = 64'd100;
        model_clear();
        #12;
        check_reset_outputs("reset");
`ifdef PIPE_CHAIN_PERF_EN
        chk("rst_perf", SW'(perf_stall_cnt | perf_bubble_cnt
                            | perf_kill_cnt), '0);
`endif
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Streaming 1..10 with everything ready.
        for (int v = 1; v <= 10; v++) step(1, DW'(v), '1, 0, '0, 1);
        idle(6, 1);

        // Fill 1..5 behind a blocked output, then stall stage 2.
        for (int v = 1; v <= 5; v++) step(1, DW'(v), '1, 0, '0, 0);
        for (int c = 0; c < 3; c++) step(1, 64'd99, 5'b11011, 0, '0, 1);
        idle(6, 1);

        // Full pipe under output backpressure, then drain.
        for (int v = 1; v <= 5; v++) step(1, DW'(v), '1, 0, '0, 0);
        for (int c = 0; c < 4; c++) step(1, 64'd77, '1, 0, '0, 0);
        idle(6, 1);

        // Flush at stage 2 with a full pipe of 10..50.
        for (int v = 1; v <= 5; v++) step(1, DW'(v * 10), '1, 0, '0, 0);
        step(1, 64'd60, '1, 1, FSW'(2), 1);
        chk("flush2_sv", SW'(stage_valid), SW'(5'b11000));
        idle(4, 1);

        // Flush boundaries: index 0 then index beyond the last stage.
        for (int v = 1; v <= 5; v++) step(1, DW'(v), '1, 0, '0, 0);
        step(1, 64'd66, '1, 1, FSW'(0), 1);
        step(1, 64'd67, '1, 1, FSW'(7), 1);
        chk("flush7_sv", SW'(stage_valid), '0);
        idle(3, 1);

        // Three blocked input cycles on a full pipe.
        for (int v = 1; v <= 5; v++) step(1, DW'(v), '1, 0, '0, 0);
        for (int c = 0; c < 3; c++) step(1, 64'd88, '1, 0, '0, 0);

        // Randomized phases with varying pressure.
        for (int j = 0; j < 1500; j++) begin
            case (j / 300)
                0: begin p_in = 90; p_rg = 95; p_or = 95; p_fl = 3;  end
                1: begin p_in = 70; p_rg = 70; p_or = 60; p_fl = 8;  end
                2: begin p_in = 95; p_rg = 85; p_or = 30; p_fl = 5;  end
                3: begin p_in = 40; p_rg = 50; p_or = 90; p_fl = 15; end
                default: begin p_in = 80; p_rg = 80; p_or = 80; p_fl = 6; end
            endcase
            for (int i = 0; i < N; i++) begin
                rg[i] = ($urandom_range(0, 99) < p_rg);
            end
            seq++;
            dv = {$urandom, seq[31:0]};
            step($urandom_range(0, 99) < p_in, dv, rg,
                 $urandom_range(0, 99) < p_fl,
                 FSW'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < p_or);
        end

        // Asynchronous reset between edges with a full pipe.
        for (int v = 1; v <= 5; v++) step(1, DW'(v + 200), '1, 0, '0, 0);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        in_valid       = 1'b0;
        stage_ready_go = '0;
        out_ready      = 1'b0;
        flush_req      = 1'b0;
        model_clear();
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) step(1, DW'(c + 300), '1, 0, '0, 1);
        idle(6, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule
